// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue, operand-query and status bundle for the hazard scoreboard
interface hazard_scoreboard_if #(parameter int AW = 5, parameter int NRD = 2, parameter int CW = 4);
  logic issue_valid, issue_ready, issue_we, flush, stall;
  logic [AW-1:0] issue_rd;
  logic [CW-1:0] issue_lat;
  logic [NRD-1:0] rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [2*NRD-1:0] fwd_sel;
  logic [AW:0] pend_cnt;
  logic [15:0] stall_cycles;
  modport master(output issue_valid, issue_we, issue_rd, issue_lat, rd_en, rd_addr, flush,
                 input issue_ready, fwd_sel, stall, pend_cnt, stall_cycles);
  modport slave(input issue_valid, issue_we, issue_rd, issue_lat, rd_en, rd_addr, flush,
                output issue_ready, fwd_sel, stall, pend_cnt, stall_cycles);
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency counters giving forward selects, operand/WAW stalls and stats
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int CW = 4
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave bus
);
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [AW:0] pend_q, pend_d;
  logic [15:0] sc_q;
  logic [NRD-1:0] hz;
  logic [2*NRD-1:0] fwd;
  logic waw, stall, load;
  always_comb begin
    hz = '0;
    fwd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.rd_en[i] && bus.rd_addr[i*AW +: AW] != '0) begin
        hz[i] = cnt_q[bus.rd_addr[i*AW +: AW]] >= CW'(3);
        fwd[2*i +: 2] = cnt_q[bus.rd_addr[i*AW +: AW]] == CW'(1) ? 2'b01 :
                        cnt_q[bus.rd_addr[i*AW +: AW]] == CW'(2) ? 2'b10 : 2'b00;
      end
    end
    waw = bus.issue_valid && bus.issue_we && bus.issue_rd != '0 && bus.issue_lat < cnt_q[bus.issue_rd];
    stall = bus.issue_valid && (|hz || waw);
    load = bus.issue_valid && !stall && bus.issue_we && bus.issue_rd != '0 && !bus.flush;
  end
  // a flush only kills writes still three or more cycles out; MEM/WB results keep draining
  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = r == 0 ? '0 :
                 load && bus.issue_rd == AW'(r) ? bus.issue_lat :
                 bus.flush && cnt_q[r] >= CW'(3) ? '0 :
                 cnt_q[r] != '0 ? cnt_q[r] - 1'b1 : '0;
      pend_d = pend_d + (AW+1)'(cnt_d[r] != '0);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
      pend_q <= '0;
      sc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      sc_q <= sc_q + 16'(stall && sc_q != 16'hFFFF);
    end
  end
  assign bus.fwd_sel = fwd;
  assign bus.stall = stall;
  assign bus.issue_ready = !stall;
  assign bus.pend_cnt = pend_q;
  assign bus.stall_cycles = sc_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven directed vectors plus reset and saturation sequences
module tb_hazard_scoreboard;
  typedef struct {
    logic v, we, fl, st;
    logic [4:0] rd, a0, a1;
    logic [3:0] lat, fwd;
    logic [1:0] en;
    logic [5:0] pend;
    logic [15:0] sc;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int n_chk = 0, n_err = 0;
  vec_t tbl [26];
  hazard_scoreboard_if #(.AW(5), .NRD(2), .CW(4)) bus();
  hazard_scoreboard #(.NREG(32), .AW(5), .NRD(2), .CW(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic we, logic [4:0] rd, logic [3:0] lat, logic fl, logic [1:0] en,
                              logic [4:0] a0, logic [4:0] a1, logic [3:0] fwd, logic st, logic [5:0] pend, logic [15:0] sc);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.lat = lat; t.fl = fl; t.en = en; t.a0 = a0; t.a1 = a1;
    t.fwd = fwd; t.st = st; t.pend = pend; t.sc = sc;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic v, logic we, logic [4:0] rd, logic [3:0] lat, logic fl, logic [1:0] en, logic [4:0] a0, logic [4:0] a1);
    bus.issue_valid = v; bus.issue_we = we; bus.issue_rd = rd; bus.issue_lat = lat;
    bus.flush = fl; bus.rd_en = en; bus.rd_addr = {a1, a0};
  endtask
  task automatic cyc(logic v, logic we, logic [4:0] rd, logic [3:0] lat, logic [1:0] en, logic [4:0] a0);
    drive(v, we, rd, lat, 1'b0, en, a0, 5'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = mk(1,1,5,2,0,2'b01,5,0, 4'b0000,0,1,0);
    tbl[1]  = mk(0,0,0,0,0,2'b01,5,0, 4'b0010,0,1,0);
    tbl[2]  = mk(1,0,0,0,0,2'b01,5,0, 4'b0001,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,2'b01,5,0, 4'b0000,0,0,0);
    tbl[4]  = mk(1,1,7,4,0,2'b10,0,7, 4'b0000,0,1,0);
    tbl[5]  = mk(1,0,0,0,0,2'b01,7,0, 4'b0000,1,1,1);
    tbl[6]  = mk(1,0,0,0,0,2'b01,7,0, 4'b0000,1,1,2);
    tbl[7]  = mk(1,0,0,0,0,2'b01,7,0, 4'b0010,0,1,2);
    tbl[8]  = mk(1,0,0,0,0,2'b01,7,0, 4'b0001,0,0,2);
    tbl[9]  = mk(1,0,0,0,0,2'b01,7,0, 4'b0000,0,0,2);
    tbl[10] = mk(1,1,3,5,0,2'b00,0,0, 4'b0000,0,1,2);
    tbl[11] = mk(1,1,3,2,0,2'b00,0,0, 4'b0000,1,1,3);
    tbl[12] = mk(1,1,3,2,0,2'b00,0,0, 4'b0000,1,1,4);
    tbl[13] = mk(1,1,3,2,0,2'b00,0,0, 4'b0000,1,1,5);
    tbl[14] = mk(1,1,3,2,0,2'b00,0,0, 4'b0000,0,1,5);
    tbl[15] = mk(0,0,0,0,0,2'b10,0,3, 4'b1000,0,1,5);
    tbl[16] = mk(0,0,0,0,0,2'b00,0,0, 4'b0000,0,0,5);
    tbl[17] = mk(1,1,4,7,0,2'b00,0,0, 4'b0000,0,1,5);
    tbl[18] = mk(1,1,9,2,0,2'b00,0,0, 4'b0000,0,2,5);
    tbl[19] = mk(1,1,12,5,1,2'b11,12,9, 4'b1000,0,1,5);
    tbl[20] = mk(1,0,0,0,0,2'b11,4,9, 4'b0100,0,0,5);
    tbl[21] = mk(1,1,0,5,0,2'b01,0,0, 4'b0000,0,0,5);
    tbl[22] = mk(0,0,0,0,0,2'b11,0,0, 4'b0000,0,0,5);
    tbl[23] = mk(1,1,6,9,0,2'b00,0,0, 4'b0000,0,1,5);
    tbl[24] = mk(1,0,0,0,0,2'b00,6,0, 4'b0000,0,1,5);
    tbl[25] = mk(1,0,0,0,0,2'b10,0,6, 4'b0000,1,1,6);
    drive(0,0,0,0,0,2'b00,0,0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset pend_cnt", 32'(bus.pend_cnt), 0);
    chk("reset stall_cycles", 32'(bus.stall_cycles), 0);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset issue_ready", 32'(bus.issue_ready), 1);
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].lat, tbl[i].fl, tbl[i].en, tbl[i].a0, tbl[i].a1);
      #2;
      chk($sformatf("v%0d fwd_sel", i), 32'(bus.fwd_sel), 32'(tbl[i].fwd));
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tbl[i].st));
      chk($sformatf("v%0d issue_ready", i), 32'(bus.issue_ready), 32'(!tbl[i].st));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pend_cnt", i), 32'(bus.pend_cnt), 32'(tbl[i].pend));
      chk($sformatf("v%0d stall_cycles", i), 32'(bus.stall_cycles), 32'(tbl[i].sc));
    end
    repeat (8) cyc(0,0,0,0,2'b00,0);
    cyc(1,1,3,9,2'b00,0);
    cyc(1,1,2,9,2'b00,0);
    cyc(1,1,1,2,2'b00,0);
    chk("pre-reset pend_cnt", 32'(bus.pend_cnt), 3);
    drive(0,0,0,0,0,2'b11,1,2);
    #1;
    chk("pre-reset fwd_sel", 32'(bus.fwd_sel), 32'(4'b0010));
    #1 reset = 1'b1;
    #1;
    chk("async reset pend_cnt", 32'(bus.pend_cnt), 0);
    chk("async reset fwd_sel", 32'(bus.fwd_sel), 0);
    chk("async reset stall_cycles", 32'(bus.stall_cycles), 0);
    chk("async reset stall", 32'(bus.stall), 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset pend_cnt", 32'(bus.pend_cnt), 0);
    chk("post-reset fwd_sel", 32'(bus.fwd_sel), 0);
    for (int k = 0; k < 5042; k++) begin
      cyc(1,1,1,15,2'b00,0);
      repeat (13) cyc(1,0,0,0,2'b01,1);
      if (k == 0) chk("stall_cycles after 13 stalls", 32'(bus.stall_cycles), 13);
    end
    chk("stall_cycles saturated", 32'(bus.stall_cycles), 32'hFFFF);
    cyc(1,1,1,15,2'b00,0);
    repeat (4) cyc(1,0,0,0,2'b01,1);
    chk("stall_cycles held", 32'(bus.stall_cycles), 32'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
